// File: rtl/mbd_pkg.sv
// mbd_pkg: shared FSM state type and parameter defaults for the multi-button debouncer
package mbd_pkg;
    typedef enum logic [1:0] {IDLE, ARMING, PRESSED, DISARMING} mbd_state_e;
    localparam int DEF_N_CH           = 4;
    localparam int DEF_TICK_DIV       = 250000;
    localparam int DEF_STABLE_SAMPLES = 4;
    localparam int DEF_LONG_TICKS     = 500;
    localparam int DEF_ACTIVE_LOW     = 1;
endpackage

// File: rtl/mbd_channel.sv
// mbd_channel: one button channel with synchroniser, debounce FSM, hold counter and event pulses
module mbd_channel
    import mbd_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int LONG_TICKS     = DEF_LONG_TICKS,
    parameter int ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic REL = (ACTIVE_LOW != 0);
    logic sync1_q, sync2_q;
    mbd_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic btn_state_q, btn_state_d, press_q, press_d, release_q, release_d, long_q, long_d;
    logic s, on_side, cand;
    assign s        = sync2_q ^ REL;
    assign on_side  = (state_q == PRESSED) || (state_q == DISARMING);
    assign cand     = on_side ? ~s : s;
    assign cnt_inc  = cnt_q + 1'b1;
    assign hold_inc = hold_q + 1'b1;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        if (tick) begin
            if (on_side && hold_q != HW'(LONG_TICKS)) begin
                hold_d = hold_inc;
                long_d = (hold_inc == HW'(LONG_TICKS));
            end
            if (cand && cnt_inc == CW'(STABLE_SAMPLES)) begin
                state_d   = on_side ? IDLE : PRESSED;
                cnt_d     = '0;
                hold_d    = '0;
                press_d   = ~on_side;
                release_d = on_side;
            end else if (cand) begin
                state_d = on_side ? DISARMING : ARMING;
                cnt_d   = cnt_inc;
            end else begin
                // an aborted candidate falls back silently to the committed level
                state_d = on_side ? PRESSED : IDLE;
                cnt_d   = '0;
            end
        end
        btn_state_d = (state_d == PRESSED) || (state_d == DISARMING);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= REL;
            sync2_q     <= REL;
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            btn_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            btn_state_q <= btn_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end
    assign btn_state     = btn_state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
endmodule

// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer: shared sample prescaler driving N_CH independent debounce channels
module multi_button_debouncer
    import mbd_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int LONG_TICKS     = DEF_LONG_TICKS,
    parameter int ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic            sample_tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [PW-1:0] div_q, div_d;
    logic tick;
    assign tick        = (div_q == PW'(TICK_DIV - 1));
    assign div_d       = tick ? '0 : div_q + 1'b1;
    assign sample_tick = tick;
    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mbd_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .LONG_TICKS    (LONG_TICKS),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .btn_raw      (btn_raw[i]),
            .btn_state    (btn_state[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_press   (long_press[i])
        );
    end
endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb_multi_button_debouncer: directed scenarios plus random stimulus against a tick-level reference model
module tb_multi_button_debouncer;
    localparam int TD = 4;
    localparam int SS = 3;
    localparam int LT = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] raw_a = 2'b11;
    logic [1:0] raw_b = 2'b00;
    logic [1:0] st_a, pp_a, rp_a, lp_a, st_b, pp_b, rp_b, lp_b;
    logic tk_a, tk_b;
    int n_cmp = 0;
    int n_bad = 0;
    int ph = 0;
    bit m_tick = 1'b0;
    bit h1[4], h2[4], lvl[4], mpp[4], mrp[4], mlp[4];
    int run[4], held[4];
    int c_pp0, c_rp0, c_lp0, c_ppb1;
    bit both;

    always #5 clk = ~clk;

    multi_button_debouncer #(.N_CH(2), .TICK_DIV(TD), .STABLE_SAMPLES(SS), .LONG_TICKS(LT), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .btn_raw(raw_a), .btn_state(st_a), .press_pulse(pp_a),
        .release_pulse(rp_a), .long_press(lp_a), .sample_tick(tk_a));
    multi_button_debouncer #(.N_CH(2), .TICK_DIV(TD), .STABLE_SAMPLES(SS), .LONG_TICKS(LT), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .btn_raw(raw_b), .btn_state(st_b), .press_pulse(pp_b),
        .release_pulse(rp_b), .long_press(lp_b), .sample_tick(tk_b));

    function automatic bit raw_of(int c);
        logic [3:0] all_raw;
        all_raw = {raw_b, raw_a};
        return all_raw[c[1:0]];
    endfunction

    // Channels 0-1 are active-low (dut_a), 2-3 active-high (dut_b); level = debounced pressed flag.
    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            mpp[c] = 1'b0; mrp[c] = 1'b0; mlp[c] = 1'b0;
        end
        if (rst) begin
            ph = 0; m_tick = 1'b0;
            for (int c = 0; c < 4; c++) begin
                h1[c] = (c < 2); h2[c] = (c < 2); lvl[c] = 1'b0; run[c] = 0; held[c] = 0;
            end
        end else begin
            m_tick = (ph == TD - 1);
            ph = m_tick ? 0 : ph + 1;
            for (int c = 0; c < 4; c++) begin
                bit s;
                s = (c < 2) ? !h2[c] : h2[c];
                if (m_tick) begin
                    if (lvl[c] && held[c] < LT) begin
                        held[c]++;
                        if (held[c] == LT) mlp[c] = 1'b1;
                    end
                    if (s != lvl[c]) begin
                        run[c]++;
                        if (run[c] == SS) begin
                            lvl[c] = !lvl[c]; run[c] = 0; held[c] = 0;
                            mpp[c] = lvl[c]; mrp[c] = !lvl[c];
                        end
                    end else run[c] = 0;
                end
                h2[c] = h1[c];
                h1[c] = raw_of(c);
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check("state_a", st_a, {lvl[1], lvl[0]});
            check("press_a", pp_a, {mpp[1], mpp[0]});
            check("release_a", rp_a, {mrp[1], mrp[0]});
            check("long_a", lp_a, {mlp[1], mlp[0]});
            check("tick_a", tk_a, (ph == TD - 1));
            check("state_b", st_b, {lvl[3], lvl[2]});
            check("press_b", pp_b, {mpp[3], mpp[2]});
            check("release_b", rp_b, {mrp[3], mrp[2]});
            check("long_b", lp_b, {mlp[3], mlp[2]});
            check("tick_b", tk_b, (ph == TD - 1));
            if (pp_a[0]) c_pp0++;
            if (rp_a[0]) c_rp0++;
            if (lp_a[0]) c_lp0++;
            if (pp_b[1]) c_ppb1++;
            if (pp_a == 2'b11) both = 1'b1;
        end
    endtask

    task automatic step_ticks(int k);
        int seen = 0;
        int guard = 0;
        while (seen < k && guard < 64 * k) begin
            step(1);
            if (m_tick) seen++;
            guard++;
        end
        check("tick_wait", seen, k);
    endtask

    task automatic clear_counts();
        c_pp0 = 0; c_rp0 = 0; c_lp0 = 0; c_ppb1 = 0; both = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();
        step(3);
        check("rst_outputs", {st_a, pp_a, rp_a, lp_a, st_b, pp_b, rp_b, lp_b}, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1);
            check("tick_gap", tk_a, 0);
        end
        step(1);
        check("tick_first", tk_a, 1);
        step_ticks(1);
        // clean press: commit visible right after the 3rd agreeing tick
        raw_a[0] = 1'b0;
        step_ticks(2);
        check("clean_pre", st_a[0], 0);
        step_ticks(1);
        check("clean_state", st_a[0], 1);
        check("clean_pulse", pp_a[0], 1);
        // long press: 5 ticks after commit, once only
        step_ticks(4);
        check("long_early", c_lp0, 0);
        step_ticks(1);
        check("long_fire", lp_a[0], 1);
        step_ticks(8);
        check("long_once", c_lp0, 1);
        raw_a[0] = 1'b1;
        step_ticks(2);
        check("rel_pre", st_a[0], 1);
        step_ticks(1);
        check("rel_state", st_a[0], 0);
        check("rel_pulse", rp_a[0], 1);
        check("rel_count", c_rp0, 1);
        check("press_count", c_pp0, 1);
        check("long_after_rel", c_lp0, 1);
        // bounce: 2 low ticks, 1 high, then low
        clear_counts();
        raw_a[0] = 1'b0;
        step_ticks(2);
        raw_a[0] = 1'b1;
        step_ticks(1);
        check("bounce_none", c_pp0, 0);
        raw_a[0] = 1'b0;
        step_ticks(2);
        check("bounce_pre", st_a[0], 0);
        step_ticks(1);
        check("bounce_state", st_a[0], 1);
        step_ticks(2);
        check("bounce_count", c_pp0, 1);
        raw_a = 2'b11;
        step_ticks(4);
        // simultaneous press on both channels
        clear_counts();
        raw_a = 2'b00;
        step_ticks(4);
        check("simul_both", both, 1);
        check("simul_count", c_pp0, 1);
        raw_a = 2'b11;
        step_ticks(4);
        // reset while arming
        raw_a[0] = 1'b0;
        step_ticks(1);
        clear_counts();
        rst = 1'b1;
        raw_a = 2'b11;
        step(1);
        check("rst_arm_out", {st_a, pp_a, rp_a, lp_a, tk_a}, 0);
        step(1);
        rst = 1'b0;
        step_ticks(5);
        check("rst_arm_press", c_pp0, 0);
        check("rst_arm_rel", c_rp0, 0);
        // reset while pressed
        raw_a[0] = 1'b0;
        step_ticks(5);
        check("pressed_before_rst", st_a[0], 1);
        clear_counts();
        rst = 1'b1;
        raw_a = 2'b11;
        step(1);
        check("rst_prs_out", {st_a, pp_a, rp_a, lp_a, tk_a}, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1);
            check("rst_tick_gap", tk_a, 0);
        end
        step(1);
        check("rst_tick_resume", tk_a, 1);
        step_ticks(4);
        check("rst_prs_rel", c_rp0, 0);
        check("rst_prs_press", c_pp0, 0);
        // active-high polarity on dut_b channel 1
        clear_counts();
        raw_b[1] = 1'b1;
        step_ticks(2);
        check("pol_pre", st_b[1], 0);
        step_ticks(1);
        check("pol_state", st_b[1], 1);
        check("pol_pulse", pp_b[1], 1);
        check("pol_count", c_ppb1, 1);
        // random stimulus
        for (int i = 0; i < 400; i++) begin
            raw_a = 2'($urandom());
            raw_b = 2'($urandom());
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                step(2);
                rst = 1'b0;
            end
            step(int'($urandom_range(1, 24)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
